press_event_encoder: RTL

Drives the press interface consumed by the game's display/scoring block. Samples four raw lane buttons, selects one active lane, and produces `position`, `is_pressing` and a saturating `press_time` duration count timed by the shared `Div` counter. On release it emits a one-cycle `keyReady` strobe, completing the press transaction. Sits between the board button pins and the display/scoring logic.

---
 rtl/press_event_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/press_event_encoder.sv
// ---------------------------------------------------------------------------
// press_event_encoder : lane button sync/select, press timing, keyReady strobe
// Rev 1.0 -- optional debounce filter enabled by defining PRESS_DEBOUNCE_EN
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module press_event_encoder #(
  parameter int TICK_BIT        = 22,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Div,
  input  logic [3:0]  btn,
  output logic [1:0]  position,
  output logic        is_pressing,
  output logic [3:0]  press_time,
  output logic        keyReady
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_HELD     = 2'd1;
  localparam logic [1:0] S_REPORT   = 2'd2;
  localparam logic [1:0] S_WAIT_REL = 2'd3;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_btn_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 4'b0;
      r_sync2 <= 4'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PRESS_DEBOUNCE_EN
  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [CNT_W-1:0] r_cnt;
    logic             r_flt;

    // Counter runs only while the synchronized level disagrees with the filtered one
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
        r_flt <= 1'b0;
      end else if (r_sync2[gi] == r_flt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_flt <= r_sync2[gi];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_btn_f[gi] = r_flt;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (DEBOUNCE_CYCLES > 0);
  assign w_btn_f      = r_sync2;
`endif

  logic r_div_prev;
  logic w_tick;
  logic w_unused_div;

  always_ff @(posedge clk) begin
    if (rst) r_div_prev <= 1'b0;
    else     r_div_prev <= Div[TICK_BIT];
  end

  assign w_tick       = Div[TICK_BIT] & ~r_div_prev;
  assign w_unused_div = ^Div;

  logic [1:0] w_low_lane;

  always_comb begin
    w_low_lane = 2'd0;
    if      (w_btn_f[0]) w_low_lane = 2'd0;
    else if (w_btn_f[1]) w_low_lane = 2'd1;
    else if (w_btn_f[2]) w_low_lane = 2'd2;
    else if (w_btn_f[3]) w_low_lane = 2'd3;
  end

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [1:0] w_pos_nxt;
  logic       w_press_nxt;
  logic [3:0] w_time_nxt;
  logic       w_kr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      position    <= 2'd0;
      is_pressing <= 1'b0;
      press_time  <= 4'd0;
      keyReady    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      position    <= w_pos_nxt;
      is_pressing <= w_press_nxt;
      press_time  <= w_time_nxt;
      keyReady    <= w_kr_nxt;
    end
  end

  // WAIT_REL blocks a still-held second lane from starting a press without a fresh edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (|w_btn_f) w_state_nxt = S_HELD;
      S_HELD:     if (!w_btn_f[position]) w_state_nxt = S_REPORT;
      S_REPORT:   w_state_nxt = (|w_btn_f) ? S_WAIT_REL : S_IDLE;
      S_WAIT_REL: if (w_btn_f == 4'b0) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Release takes priority over a coincident tick
  always_comb begin
    w_pos_nxt   = position;
    w_press_nxt = is_pressing;
    w_time_nxt  = press_time;
    w_kr_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_btn_f) begin
          w_pos_nxt   = w_low_lane;
          w_time_nxt  = 4'd0;
          w_press_nxt = 1'b1;
        end
      end
      S_HELD: begin
        if (!w_btn_f[position]) begin
          w_press_nxt = 1'b0;
          w_kr_nxt    = 1'b1;
        end else if (w_tick && (press_time != 4'hF)) begin
          w_time_nxt = press_time + 4'd1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire
